// File: rtl/pipeline_ctrl.sv
// Central hazard sequencer for the 5-stage LEGv8 pipeline.
// Inputs: ID/EX/MEM hazard fields, dmem_ready; outputs: stage enables/flushes, dmem_req, perf counters, mem_timeout.
module pipeline_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_write_reg,
    input  logic             ex_mem_branch,
    input  logic             ex_mem_uncbranch,
    input  logic             ex_mem_zero,
    input  logic             ex_mem_memread,
    input  logic             ex_mem_memwrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             pc_src,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             ex_mem_flush,
    output logic             mem_wb_write,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_timeout
);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CMAX    = '1;

    logic [1:0]      state;
    logic [1:0]      state_nx;
    logic [WC_W-1:0] wcnt;
    logic            mem_op;
    logic            taken;
    logic            hazard;
    logic            taken_cyc;

    assign mem_op = ex_mem_memread | ex_mem_memwrite;
    assign taken  = (ex_mem_branch & ex_mem_zero) | ex_mem_uncbranch;

    // XZR as destination never forwards a real value, so never stalls.
    assign hazard = id_ex_memread
                  & (id_ex_write_reg != 5'd31)
                  & ((id_ex_write_reg == id_rn)
                     | (id_uses_rm & (id_ex_write_reg == id_rm)));

    always_comb begin
        state_nx     = state;
        dmem_req     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_write = 1'b0;
        taken_cyc    = 1'b0;
        if (reset_n) begin
            unique case (state)
                S_RUN: begin
                    dmem_req = mem_op;
                    if (mem_op && !dmem_ready) begin
                        state_nx = S_WAIT;
                    end else if (taken) begin
                        // Squashes whatever is younger, load-use included.
                        taken_cyc    = 1'b1;
                        pc_src       = 1'b1;
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        id_ex_write  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (hazard) begin
                        id_ex_write  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                    end else begin
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        id_ex_write  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                    end
                end
                S_WAIT: begin
                    dmem_req = mem_op;
                    if (dmem_ready) begin
                        state_nx     = S_RUN;
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        id_ex_write  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                    end else if (wcnt == WC_LAST) begin
                        state_nx = S_ERR;
                    end
                end
                S_ERR: begin
                    state_nx = S_ERR;
                end
                default: begin
                    state_nx = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_RUN;
            wcnt         <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state != S_WAIT) begin
                wcnt <= '0;
            end else if (!dmem_ready && wcnt != WC_LAST) begin
                wcnt <= wcnt + 1'b1;
            end
            if (!pc_write && stall_cycles != CMAX) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (taken_cyc && flush_events != CMAX) begin
                flush_events <= flush_events + 1'b1;
            end
            if (state_nx == S_ERR) begin
                mem_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl.
// Drives hazard scenarios; expected control words queued per cycle and compared.
module tb_pipeline_ctrl;

    localparam int CW = 4;

    // {dmem_req,pc_write,pc_src,if_id_write,if_id_flush,
    //  id_ex_write,id_ex_flush,ex_mem_write,ex_mem_flush,mem_wb_write}
    localparam logic [9:0] C_NORM = 10'b0101010101;
    localparam logic [9:0] C_LU   = 10'b0000011101;
    localparam logic [9:0] C_BR   = 10'b0111111111;
    localparam logic [9:0] C_MSTL = 10'b1000000000;
    localparam logic [9:0] C_MGO  = 10'b1101010101;
    localparam logic [9:0] C_OFF  = 10'b0000000000;

    typedef struct {
        string      nm;
        logic [9:0] exp;
    } sb_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [4:0]    id_rn, id_rm, id_ex_write_reg;
    logic          id_uses_rm, id_ex_memread;
    logic          ex_mem_branch, ex_mem_uncbranch, ex_mem_zero;
    logic          ex_mem_memread, ex_mem_memwrite, dmem_ready;
    logic          dmem_req, pc_write, pc_src, if_id_write, if_id_flush;
    logic          id_ex_write, id_ex_flush, ex_mem_write, ex_mem_flush;
    logic          mem_wb_write, mem_timeout;
    logic [CW-1:0] stall_cycles, flush_events;
    logic [9:0]    ctl;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    pipeline_ctrl #(.CNT_W(CW), .TIMEOUT(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .id_ex_memread(id_ex_memread), .id_ex_write_reg(id_ex_write_reg),
        .ex_mem_branch(ex_mem_branch), .ex_mem_uncbranch(ex_mem_uncbranch),
        .ex_mem_zero(ex_mem_zero), .ex_mem_memread(ex_mem_memread),
        .ex_mem_memwrite(ex_mem_memwrite), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_write(pc_write), .pc_src(pc_src),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
        .mem_wb_write(mem_wb_write), .stall_cycles(stall_cycles),
        .flush_events(flush_events), .mem_timeout(mem_timeout)
    );

    always #5 clock = ~clock;

    assign ctl = {dmem_req, pc_write, pc_src, if_id_write, if_id_flush,
                  id_ex_write, id_ex_flush, ex_mem_write, ex_mem_flush,
                  mem_wb_write};

    task automatic idle();
        id_rn = 5'd0; id_rm = 5'd0; id_uses_rm = 1'b0;
        id_ex_memread = 1'b0; id_ex_write_reg = 5'd0;
        ex_mem_branch = 1'b0; ex_mem_uncbranch = 1'b0; ex_mem_zero = 1'b0;
        ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0; dmem_ready = 1'b0;
    endtask

    // Queue expectation, compare once outputs settle, then cross an edge.
    task automatic expect_ctl(input string nm, input logic [9:0] exp);
        sb_t e;
        sb.push_back('{nm, exp});
        #1;
        e = sb.pop_front();
        checks++;
        if (ctl !== e.exp) begin
            errors++;
            $display("FAIL %s: ctl got %b want %b", e.nm, ctl, e.exp);
        end
    endtask

    task automatic step(input string nm, input logic [9:0] exp);
        expect_ctl(nm, exp);
        @(posedge clock);
        #1;
    endtask

    task automatic chk_cnt(input string nm, input logic [CW-1:0] st,
                           input logic [CW-1:0] fl, input logic to);
        checks++;
        if (stall_cycles !== st || flush_events !== fl || mem_timeout !== to) begin
            errors++;
            $display("FAIL %s: stall/flush/to got %0d/%0d/%b want %0d/%0d/%b",
                     nm, stall_cycles, flush_events, mem_timeout, st, fl, to);
        end
    endtask

    task automatic test_reset();
        idle();
        ex_mem_memread = 1'b1;
        reset_n = 1'b0;
        expect_ctl("reset_outputs", C_OFF);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk_cnt("reset_counters", 0, 0, 1'b0);
        idle();
        reset_n = 1'b1;
    endtask

    task automatic test_load_use();
        step("run_idle", C_NORM);
        id_ex_memread = 1'b1; id_ex_write_reg = 5'd2; id_rn = 5'd2;
        step("load_use", C_LU);
        idle();
        ex_mem_memread = 1'b1; dmem_ready = 1'b1;
        step("load_in_mem", C_MGO);
        chk_cnt("load_use_cnt", 1, 0, 1'b0);
        idle();
    endtask

    task automatic test_no_dep();
        id_ex_memread = 1'b1; id_ex_write_reg = 5'd31; id_rn = 5'd31;
        step("xzr_no_stall", C_NORM);
        id_ex_write_reg = 5'd3; id_rn = 5'd5; id_rm = 5'd3; id_uses_rm = 1'b0;
        step("rm_unused", C_NORM);
        id_uses_rm = 1'b1; id_rm = 5'd31; id_ex_write_reg = 5'd31;
        step("xzr_rm", C_NORM);
        chk_cnt("no_dep_cnt", 1, 0, 1'b0);
        idle();
    endtask

    task automatic test_branch();
        id_ex_memread = 1'b1; id_ex_write_reg = 5'd2; id_rn = 5'd2;
        ex_mem_branch = 1'b1; ex_mem_zero = 1'b1;
        step("cbz_taken", C_BR);
        chk_cnt("cbz_cnt", 1, 1, 1'b0);
        idle();
        ex_mem_branch = 1'b1; ex_mem_zero = 1'b0;
        step("cbz_not_taken", C_NORM);
        idle();
        ex_mem_uncbranch = 1'b1;
        step("uncond_b", C_BR);
        chk_cnt("branch_cnt", 1, 2, 1'b0);
        idle();
    endtask

    task automatic test_mem_wait();
        ex_mem_memread = 1'b1;
        for (int i = 0; i < 3; i++) step("mem_wait", C_MSTL);
        dmem_ready = 1'b1;
        step("mem_done", C_MGO);
        idle();
        step("mem_back_run", C_NORM);
        chk_cnt("mem_wait_cnt", 4, 2, 1'b0);
    endtask

    task automatic test_timeout();
        ex_mem_memwrite = 1'b1;
        for (int i = 0; i < 5; i++) step("to_wait", C_MSTL);
        chk_cnt("to_enter", 9, 2, 1'b1);
        for (int i = 0; i < 8; i++) step("to_error", C_OFF);
        dmem_ready = 1'b1;
        step("to_ready_ignored", C_OFF);
        chk_cnt("to_saturate", 15, 2, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_cnt("to_reset_clear", 0, 0, 1'b0);
        @(posedge clock);
        #1;
        idle();
        reset_n = 1'b1;
        step("to_after_reset", C_NORM);
    endtask

    task automatic test_async_reset();
        ex_mem_memread = 1'b1;
        step("ar_run", C_MSTL);
        expect_ctl("ar_wait", C_MSTL);
        #2;
        reset_n = 1'b0;
        expect_ctl("ar_async_off", C_OFF);
        chk_cnt("ar_cnt_clear", 0, 0, 1'b0);
        @(posedge clock);
        #1;
        idle();
        reset_n = 1'b1;
        step("ar_release_run", C_NORM);
        chk_cnt("ar_after", 0, 0, 1'b0);
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_no_dep();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left %0d want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
